// File: rtl/pulse_stretch.sv
// Stretches single-cycle request pulses into fixed-width level pulses with a minimum low gap.
// Optional PULSE_STRETCH_RETRIGGER_EN: a request during the high phase extends it instead of queueing.
module pulse_stretch #(
    parameter int HIGH_CYCLES = 4,
    parameter int LOW_CYCLES  = 2,
    parameter int PEND_MAX    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       p,
    output logic       a,
    output logic       busy,
    output logic [3:0] pend_cnt,
    output logic       ovf
);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } state_t;

    localparam logic [7:0] H_LD  = 8'(HIGH_CYCLES - 1);
    localparam logic [7:0] L_LD  = 8'(LOW_CYCLES - 1);
    localparam logic [3:0] P_MAX = 4'(PEND_MAX);

    state_t     state, state_nx;
    logic [7:0] cnt, cnt_nx;
    logic [3:0] pend, pend_nx;
    logic       ovf_nx;
    logic       enq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 8'd0;
            pend  <= 4'd0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            pend  <= pend_nx;
            ovf   <= ovf_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pend_nx  = pend;
        ovf_nx   = 1'b0;
        enq      = 1'b0;
        unique case (state)
            IDLE: begin
                if (p) begin
                    state_nx = HIGH;
                    cnt_nx   = H_LD;
                end
            end
            HIGH: begin
`ifdef PULSE_STRETCH_RETRIGGER_EN
                if (p) begin
                    cnt_nx = H_LD;
                end else if (cnt == 8'd0) begin
                    state_nx = LOW;
                    cnt_nx   = L_LD;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
`else
                enq = p;
                if (cnt == 8'd0) begin
                    state_nx = LOW;
                    cnt_nx   = L_LD;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
`endif
            end
            LOW: begin
                if (cnt == 8'd0) begin
                    // A request on the exit edge is consumed directly, never queued
                    if (pend != 4'd0 || p) begin
                        state_nx = HIGH;
                        cnt_nx   = H_LD;
                        if (pend != 4'd0 && !p)
                            pend_nx = pend - 4'd1;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    cnt_nx = cnt - 8'd1;
                    enq    = p;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = 8'd0;
            end
        endcase
        if (enq) begin
            if (pend < P_MAX)
                pend_nx = pend + 4'd1;
            else
                ovf_nx = 1'b1;
        end
    end

    assign a        = (state == HIGH);
    assign busy     = (state != IDLE);
    assign pend_cnt = pend;

endmodule

// File: tb/tb_pulse_stretch.sv
// Randomized and directed bench for pulse_stretch against a timestamp-based reference model.
// Runs a default-parameter instance and a HIGH_CYCLES=1/LOW_CYCLES=1 instance side by side.
module tb_pulse_stretch;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       p   = 1'b0;
    logic [1:0] a_v, busy_v, ovf_v;
    logic [3:0] pc_v [2];

    int n_checks = 0;
    int n_errors = 0;

    int t = 0;
    int hc [2] = '{4, 1};
    int lc [2] = '{2, 1};
    int pm = 3;
    int hi_end [2];
    int lo_end [2];
    int q [2];
    bit act [2];
    bit ov [2];

    always #5 clk = ~clk;

    pulse_stretch u_dut0 (
        .clk(clk), .rst(rst), .p(p),
        .a(a_v[0]), .busy(busy_v[0]),
        .pend_cnt(pc_v[0]), .ovf(ovf_v[0])
    );

    pulse_stretch #(.HIGH_CYCLES(1), .LOW_CYCLES(1), .PEND_MAX(3)) u_dut1 (
        .clk(clk), .rst(rst), .p(p),
        .a(a_v[1]), .busy(busy_v[1]),
        .pend_cnt(pc_v[1]), .ovf(ovf_v[1])
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s at t=%0d: got %0d, expected %0d", tag, t, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            act[k]    = 0;
            q[k]      = 0;
            ov[k]     = 0;
            hi_end[k] = 0;
            lo_end[k] = 0;
        end
    endtask

    task automatic start_pulse(input int k);
        hi_end[k] = t + hc[k];
        lo_end[k] = hi_end[k] + lc[k];
    endtask

    task automatic enqueue(input int k);
        if (q[k] < pm) q[k]++;
        else ov[k] = 1;
    endtask

    // Pulse k is high for edges up to hi_end, low up to lo_end; lo_end is the exit edge
    task automatic model_step(input int k, input bit pv);
        ov[k] = 0;
        if (!act[k]) begin
            if (pv) begin
                act[k] = 1;
                start_pulse(k);
            end
        end else if (t <= hi_end[k]) begin
`ifdef PULSE_STRETCH_RETRIGGER_EN
            if (pv) start_pulse(k);
`else
            if (pv) enqueue(k);
`endif
        end else if (t < lo_end[k]) begin
            if (pv) enqueue(k);
        end else begin
            if (q[k] > 0 || pv) begin
                if (q[k] > 0 && !pv) q[k]--;
                start_pulse(k);
            end else begin
                act[k] = 0;
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("a%0d", k), int'(a_v[k]),
                  int'(act[k] && (t < hi_end[k])));
            check($sformatf("busy%0d", k), int'(busy_v[k]), int'(act[k]));
            check($sformatf("pend%0d", k), int'(pc_v[k]), q[k]);
            check($sformatf("ovf%0d", k), int'(ovf_v[k]), int'(ov[k]));
        end
    endtask

    task automatic cycle(input logic pv);
        p = pv;
        @(posedge clk);
        t++;
        if (rst) model_reset();
        else for (int k = 0; k < 2; k++) model_step(k, pv);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        cycle(1'b0);
        cycle(1'b0);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        #1;
        compare_all();
        cycle(1'b0);
        cycle(1'b0);
        rst = 1'b0;
        cycle(1'b0);

        cycle(1'b1);
        repeat (8) cycle(1'b0);

        cycle(1'b1);
        cycle(1'b0);
        cycle(1'b1);
        repeat (12) cycle(1'b0);

        repeat (6) cycle(1'b1);
        repeat (26) cycle(1'b0);

        cycle(1'b1);
        repeat (2) cycle(1'b0);
        cycle(1'b1);
        repeat (10) cycle(1'b0);

        cycle(1'b1);
        cycle(1'b1);
        cycle(1'b1);
        #2;
        do_reset();
        repeat (10) cycle(1'b0);

        repeat (4) cycle(1'b1);
        repeat (10) cycle(1'b0);

        for (int i = 0; i < 500; i++) begin
            if (i == 250) begin
                #2;
                do_reset();
            end
            if (i % 100 < 30)
                cycle(1'($urandom_range(0, 1)));
            else
                cycle(1'($urandom_range(0, 5) == 0));
        end
        repeat (30) cycle(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
